// File: rtl/proc_pkg.sv
// Shared definitions for the convolution processor front end: fetch FSM
// state encoding and the instruction-memory geometry constants.
package proc_pkg;

    localparam int         ADDR_W  = 6;
    localparam int         INSTR_W = 16;
    localparam logic [3:0] HALT_OP = 4'hF;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        WAIT   = 3'd2,
        ISSUE  = 3'd3,
        HALTED = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: owns the PC, addresses the synchronous
// instruction RAM and hands each word to the decoder over valid/ready.
module instr_fetch_ctrl #(
    parameter int                ADDR_W     = proc_pkg::ADDR_W,
    parameter int                INSTR_W    = proc_pkg::INSTR_W,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter logic [3:0]        HALT_OP    = proc_pkg::HALT_OP
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [ADDR_W-1:0]  instr_addr,
    input  logic [INSTR_W-1:0] instr_in,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               branch_en,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               busy,
    output logic               halted
);

    import proc_pkg::*;

    fetch_state_t       r_state;
    fetch_state_t       w_nextState;
    logic [ADDR_W-1:0]  r_pc;
    logic [INSTR_W-1:0] r_instrOut;
    logic [ADDR_W-1:0]  r_pcOut;
    logic               w_loadStart;
    logic               w_latch;
    logic               w_advance;
    logic               w_isHalt;

    assign w_isHalt = (r_instrOut[INSTR_W-1 -: 4] == HALT_OP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_loadStart = 1'b0;
        w_latch     = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            IDLE, HALTED: begin
                if (start) begin
                    w_nextState = FETCH;
                    w_loadStart = 1'b1;
                end
            end
            FETCH: w_nextState = WAIT;
            WAIT: begin
                w_nextState = ISSUE;
                w_latch     = 1'b1;
            end
            ISSUE: begin
                // A HALT word is still delivered, but it never moves the PC.
                if (instr_ready) begin
                    if (w_isHalt) begin
                        w_nextState = HALTED;
                    end else begin
                        w_nextState = FETCH;
                        w_advance   = 1'b1;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= '0;
            r_instrOut <= '0;
            r_pcOut    <= '0;
        end else begin
            if (w_loadStart) begin
                r_pc <= START_ADDR;
            end else if (w_advance) begin
                r_pc <= branch_en ? branch_target : r_pc + ADDR_W'(1);
            end
            if (w_latch) begin
                r_instrOut <= instr_in;
                r_pcOut    <= r_pc;
            end
        end
    end

    // The PC register is presented straight to the RAM, so it doubles as instr_addr.
    assign instr_addr  = r_pc;
    assign instr_out   = r_instrOut;
    assign pc_out      = r_pcOut;
    assign instr_valid = (r_state == ISSUE);
    assign busy        = (r_state == FETCH) || (r_state == WAIT) || (r_state == ISSUE);
    assign halted      = (r_state == HALTED);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl with a behavioural instruction RAM
// and a transaction-level model of which word should be presented, and when.
module tb_instr_fetch_ctrl;

    localparam int AW = 6;
    localparam int IW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] instr_addr;
    logic [IW-1:0] instr_in;
    logic [IW-1:0] instr_out;
    logic          instr_valid;
    logic          instr_ready = 1'b0;
    logic          branch_en = 1'b0;
    logic [AW-1:0] branch_target = '0;
    logic [AW-1:0] pc_out;
    logic          busy;
    logic          halted;

    instr_fetch_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .instr_addr   (instr_addr),
        .instr_in     (instr_in),
        .instr_out    (instr_out),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .branch_en    (branch_en),
        .branch_target(branch_target),
        .pc_out       (pc_out),
        .busy         (busy),
        .halted       (halted)
    );

    always #5 clk = ~clk;

    // Synchronous-read instruction RAM stand-in.
    logic [IW-1:0] mem [64];
    logic [IW-1:0] ramQ = '0;
    always @(posedge clk) ramQ <= mem[instr_addr];
    assign instr_in = ramQ;

    int compareCount  = 0;
    int mismatchCount = 0;

    // Model: mode 0 idle, 1 running, 2 halted; gap counts cycles since a fetch began.
    int            mode = 0;
    int            expPc = 0;
    int            gap = 0;
    logic [IW-1:0] lastWord = '0;
    int            startNow = 0;
    int            startPct = 0;
    int            readyPct = 100;
    int            branchHsPct = 0;
    int            branchIdlePct = 0;
    int            holdPc = -1;
    int            holdLeft = 0;
    int            branchPc = -1;
    int            branchTgt = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int cycles);
        logic expValid;
        logic ready;
        logic branch;
        logic hs;
        int   tgt;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (mode == 1) gap++;
            expValid = (mode == 1) && (gap >= 3);
            checkOutput("busy", 32'(busy), 32'(mode == 1));
            checkOutput("halted", 32'(halted), 32'(mode == 2));
            checkOutput("valid", 32'(instr_valid), 32'(expValid));
            checkOutput("addr", 32'(instr_addr), 32'(expPc));
            if (expValid) lastWord = mem[expPc];
            if (expValid || mode == 2) begin
                checkOutput("instr", 32'(instr_out), 32'(lastWord));
                checkOutput("pcOut", 32'(pc_out), 32'(expPc));
            end

            start    = (startNow != 0) || ($urandom_range(99, 0) < startPct);
            startNow = 0;
            if (expValid && expPc == holdPc && holdLeft > 0) begin
                ready = 1'b0;
                holdLeft--;
            end else begin
                ready = ($urandom_range(99, 0) < readyPct);
            end
            hs = expValid && ready;
            if (hs) branch = (expPc == branchPc) || ($urandom_range(99, 0) < branchHsPct);
            else    branch = ($urandom_range(99, 0) < branchIdlePct);
            tgt = (hs && expPc == branchPc) ? branchTgt : int'($urandom_range(63, 0));
            instr_ready   = ready;
            branch_en     = branch;
            branch_target = AW'(tgt);

            if (mode != 1 && start) begin
                mode  = 1;
                expPc = 0;
                gap   = 0;
            end else if (hs) begin
                if (lastWord[15:12] == 4'hF) begin
                    mode = 2;
                end else begin
                    expPc = branch ? tgt : (expPc + 1) % 64;
                    gap   = 0;
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;

        #1;
        checkOutput("rstValid", 32'(instr_valid), 32'd0);
        checkOutput("rstAddr", 32'(instr_addr), 32'd0);
        checkOutput("rstInstr", 32'(instr_out), 32'd0);
        checkOutput("rstPcOut", 32'(pc_out), 32'd0);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstHalted", 32'(halted), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Straight-line program ending in HALT.
        mem[0] = 16'h1001; mem[1] = 16'h2002; mem[2] = 16'h3003; mem[3] = 16'hF000;
        startNow = 1;
        applyStimulus(20);
        checkOutput("t1Halted", 32'(halted), 32'd1);
        checkOutput("t1Instr", 32'(instr_out), 32'h0000F000);

        // Decoder stalls on the word at pc 1, restart from HALTED.
        holdPc = 1; holdLeft = 5; startNow = 1;
        applyStimulus(30);
        holdPc = -1;

        // Taken branch from pc 1 to a HALT at 40.
        mem[40] = 16'hF123;
        branchPc = 1; branchTgt = 40; startNow = 1;
        applyStimulus(20);
        branchPc = -1;
        checkOutput("t3PcOut", 32'(pc_out), 32'd40);
        checkOutput("t3Instr", 32'(instr_out), 32'h0000F123);

        // No HALT words: run past pc 63 with noise on branch_en and start.
        for (int i = 0; i < 64; i++)
            mem[i] = {4'($urandom_range(14, 0)), 12'($urandom_range(4095, 0))};
        startNow = 1; readyPct = 70; branchIdlePct = 50; startPct = 10;
        applyStimulus(500);

        // Stall in ISSUE, then reset asynchronously mid-cycle.
        startPct = 0; readyPct = 0; branchIdlePct = 0;
        for (int i = 0; i < 10 && !(mode == 1 && gap >= 3); i++) applyStimulus(1);
        checkOutput("preRstValid", 32'(instr_valid), 32'd1);
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midRstValid", 32'(instr_valid), 32'd0);
        checkOutput("midRstAddr", 32'(instr_addr), 32'd0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstHalted", 32'(halted), 32'd0);
        checkOutput("midRstPcOut", 32'(pc_out), 32'd0);
        mode = 0; expPc = 0; gap = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Random programs with sparse HALTs, branches and restarts.
        for (int i = 0; i < 64; i++) begin
            mem[i] = 16'($urandom_range(65535, 0));
            if ($urandom_range(7, 0) == 0) mem[i][15:12] = 4'hF;
            else if (mem[i][15:12] == 4'hF) mem[i][15:12] = 4'h7;
        end
        startNow = 1; startPct = 20; readyPct = 60; branchHsPct = 30; branchIdlePct = 40;
        applyStimulus(2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
